xadac_obi_arbiter: RTL and testbench
====================================

# xadac_obi_arbiter

Two-to-one OBI arbiter sharing the single xadac data-memory OBI master port between the vector load unit (port 0) and the vector store unit (port 1). Grants A-channel requests through a one-entry registered slice, tags each forwarded `aid` with the source port index, and routes R-channel responses back by that tag. Per-port outstanding-transaction counters throttle each requester independently.

## Interface
- `AddrWidth`, 32, OBI address width
- `DataWidth`, 64, OBI rdata/wdata width (vector width)
- `IdWidth`, 3, requester-side ID width; master-side ID is `IdWidth+1`
- `MaxOutstanding`, 4, max in-flight transactions per port (1..2**IdWidth)

- `clk`  in  1  clock
- `rstn`  in  1  asynchronous active-low reset
- `s{0,1}_req`  in  1  A-channel request
- `s{0,1}_gnt`  out  1  A-channel grant
- `s{0,1}_addr`  in  AddrWidth  address
- `s{0,1}_we`  in  1  write enable
- `s{0,1}_be`  in  DataWidth/8  byte enables
- `s{0,1}_wdata`  in  DataWidth  write data
- `s{0,1}_aid`  in  IdWidth  request ID
- `s{0,1}_rvalid`  out  1  response valid
- `s{0,1}_rready`  in  1  response ready
- `s{0,1}_rdata`  out  DataWidth  response data
- `s{0,1}_rid`  out  IdWidth  response ID
- `m_req`  out  1  registered A-channel request
- `m_gnt`  in  1  A-channel grant
- `m_addr`, `m_we`, `m_be`, `m_wdata`  out  as slave  registered payload
- `m_aid`  out  IdWidth+1  `{port, s_aid}`
- `m_rvalid`  in  1  response valid
- `m_rready`  out  1  response ready
- `m_rdata`  in  DataWidth  response data
- `m_rid`  in  IdWidth+1  response ID; MSB = port

## Operation
- A slice: one entry, contents are the `m_*` A outputs. Slice "free" = `!m_req || m_gnt`.
- Port i eligible = `s_i_req && cnt_i < MaxOutstanding`.
- `s_i_gnt` = slice free && port i eligible && port i wins arbitration. Never both grants in one cycle.
- Arbitration: one eligible port wins; if both eligible, policy per Configuration.
- On `s_i_gnt`: next cycle `m_req=1`, payload = port i payload, `m_aid={i, s_i_aid}`.
- Slice free with no grant: `m_req` clears; payload holds last value.
- `m_req` held high, payload stable, until `m_gnt`.
- R routing, combinational: `s_i_rvalid = m_rvalid && m_rid[IdWidth]==i`; `s_i_rdata=m_rdata`, `s_i_rid=m_rid[IdWidth-1:0]` to both ports; `m_rready = s_{m_rid[IdWidth]}_rready`.
- Counters `cnt_i`, width `$clog2(MaxOutstanding+1)`: +1 on `s_i_gnt`, -1 on R handshake to port i; both same cycle -> unchanged. R handshake at `cnt_i==0` is a protocol error: counter saturates at 0, output `m_*` unaffected.
- Writes count as outstanding until their R response (OBI returns R for writes).

## Timing
- Reset values: `m_req=0`, `m_addr=0`, `m_we=0`, `m_be=0`, `m_wdata=0`, `m_aid=0`, `cnt_0=cnt_1=0`, RR pointer = port 1 (port 0 wins first contention). Combinational outputs follow inputs.
- Latency `s_i_gnt` -> `m_req`: 1 cycle. Back-to-back: with `m_gnt` tied high, one grant per cycle sustained.
- `m_gnt` and new grant in same cycle: slice reloads, `m_req` stays 1.
- Port at `cnt_i==MaxOutstanding` stalls; it regains eligibility the cycle after its R handshake (same cycle not allowed: uses registered `cnt_i`).
- R path zero-latency; no buffering, backpressure passed straight through.
- Reset mid-operation: all state cleared immediately; in-flight transactions are abandoned, no responses tracked.

## Configuration
- `XADAC_OBI_ARB_RR_EN` defined: round-robin; pointer = last granted port, updated on every grant; on contention the port not last granted wins.
- Undefined: fixed priority, port 0 always wins contention; no pointer register.

## Test plan
- Single read port 0 `addr=0x100, aid=2`, `m_gnt=1` -> `s0_gnt` cycle 0, `m_req=1, m_addr=0x100, m_aid=4'b0010` cycle 1; `m_rvalid, m_rid=4'b0010, rdata=0xDEAD` -> `s0_rvalid=1, s0_rid=2`, `s1_rvalid=0`.
- Both ports request continuously, `m_gnt=1`, RR on -> grants alternate 0,1,0,1; RR off -> port 0 every cycle, port 1 starves.
- `m_gnt=0` for 3 cycles with `m_req=1` -> payload stable, no `s_*_gnt`; `m_gnt=1` on cycle 4 -> next request granted same cycle, `m_req` stays high.
- Port 1 issues 4 requests, no responses, `MaxOutstanding=4` -> 5th request not granted while port 0 still granted; one port-1 R handshake -> port 1 granted next cycle.
- Grant and R handshake on port 0 same cycle at `cnt_0=2` -> `cnt_0` stays 2.
- Assert `rstn=0` with `m_req=1, cnt_0=3` -> `m_req=0`, counters 0 asynchronously; after release, port 0 wins first contention.

Source files
------------

// File: rtl/xadac_obi_arbiter.sv
// ============================================================================
// Module   : xadac_obi_arbiter
// Brief    : 2:1 OBI arbiter (port 0 = vector load, port 1 = vector store)
//            with a one-entry registered A slice, port-tagged aid routing of
//            R responses, and per-port outstanding limits.
//            Define XADAC_OBI_ARB_RR_EN for round-robin; default is fixed
//            priority (port 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadac_obi_arbiter #(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 64,
    parameter int IdWidth        = 3,
    parameter int MaxOutstanding = 4
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic                   s0_req,
    output logic                   s0_gnt,
    input  logic [AddrWidth-1:0]   s0_addr,
    input  logic                   s0_we,
    input  logic [DataWidth/8-1:0] s0_be,
    input  logic [DataWidth-1:0]   s0_wdata,
    input  logic [IdWidth-1:0]     s0_aid,
    output logic                   s0_rvalid,
    input  logic                   s0_rready,
    output logic [DataWidth-1:0]   s0_rdata,
    output logic [IdWidth-1:0]     s0_rid,

    input  logic                   s1_req,
    output logic                   s1_gnt,
    input  logic [AddrWidth-1:0]   s1_addr,
    input  logic                   s1_we,
    input  logic [DataWidth/8-1:0] s1_be,
    input  logic [DataWidth-1:0]   s1_wdata,
    input  logic [IdWidth-1:0]     s1_aid,
    output logic                   s1_rvalid,
    input  logic                   s1_rready,
    output logic [DataWidth-1:0]   s1_rdata,
    output logic [IdWidth-1:0]     s1_rid,

    output logic                   m_req,
    input  logic                   m_gnt,
    output logic [AddrWidth-1:0]   m_addr,
    output logic                   m_we,
    output logic [DataWidth/8-1:0] m_be,
    output logic [DataWidth-1:0]   m_wdata,
    output logic [IdWidth:0]       m_aid,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [DataWidth-1:0]   m_rdata,
    input  logic [IdWidth:0]       m_rid
);

    localparam int             CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic                   m_req_q,   m_req_d;
    logic [AddrWidth-1:0]   m_addr_q,  m_addr_d;
    logic                   m_we_q,    m_we_d;
    logic [DataWidth/8-1:0] m_be_q,    m_be_d;
    logic [DataWidth-1:0]   m_wdata_q, m_wdata_d;
    logic [IdWidth:0]       m_aid_q,   m_aid_d;
    logic [CntWidth-1:0]    cnt0_q,    cnt0_d;
    logic [CntWidth-1:0]    cnt1_q,    cnt1_d;

    logic slice_free;
    logic elig0, elig1;
    logic win0, win1;
    logic rsp0, rsp1;

    assign slice_free = !m_req_q || m_gnt;
    assign elig0      = s0_req && (cnt0_q < MaxCnt);
    assign elig1      = s1_req && (cnt1_q < MaxCnt);

`ifdef XADAC_OBI_ARB_RR_EN
    // ptr_q holds the last granted port; the other port wins contention.
    logic ptr_q, ptr_d;

    assign win0  = elig0 && (!elig1 || ptr_q);
    assign win1  = elig1 && (!elig0 || !ptr_q);
    assign ptr_d = s1_gnt ? 1'b1 : (s0_gnt ? 1'b0 : ptr_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign win0 = elig0;
    assign win1 = elig1 && !elig0;
`endif

    assign s0_gnt = slice_free && win0;
    assign s1_gnt = slice_free && win1;

    // R channel: pure combinational steering on the port tag in the ID MSB.
    assign s0_rvalid = m_rvalid && !m_rid[IdWidth];
    assign s1_rvalid = m_rvalid &&  m_rid[IdWidth];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rid    = m_rid[IdWidth-1:0];
    assign s1_rid    = m_rid[IdWidth-1:0];
    assign m_rready  = m_rid[IdWidth] ? s1_rready : s0_rready;

    assign rsp0 = s0_rvalid && s0_rready;
    assign rsp1 = s1_rvalid && s1_rready;

    always_comb begin
        m_req_d   = m_req_q;
        m_addr_d  = m_addr_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_wdata_d = m_wdata_q;
        m_aid_d   = m_aid_q;
        if (slice_free) begin
            m_req_d = s0_gnt || s1_gnt;
            if (s0_gnt) begin
                m_addr_d  = s0_addr;
                m_we_d    = s0_we;
                m_be_d    = s0_be;
                m_wdata_d = s0_wdata;
                m_aid_d   = {1'b0, s0_aid};
            end else if (s1_gnt) begin
                m_addr_d  = s1_addr;
                m_we_d    = s1_we;
                m_be_d    = s1_be;
                m_wdata_d = s1_wdata;
                m_aid_d   = {1'b1, s1_aid};
            end
        end
    end

    // A response with nothing outstanding is a protocol error; hold at zero.
    always_comb begin
        cnt0_d = cnt0_q;
        if (s0_gnt && !rsp0) begin
            cnt0_d = cnt0_q + CntWidth'(1);
        end else if (!s0_gnt && rsp0 && (cnt0_q != '0)) begin
            cnt0_d = cnt0_q - CntWidth'(1);
        end
    end

    always_comb begin
        cnt1_d = cnt1_q;
        if (s1_gnt && !rsp1) begin
            cnt1_d = cnt1_q + CntWidth'(1);
        end else if (!s1_gnt && rsp1 && (cnt1_q != '0)) begin
            cnt1_d = cnt1_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_wdata_q <= '0;
            m_aid_q   <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            m_req_q   <= m_req_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_wdata_q <= m_wdata_d;
            m_aid_q   <= m_aid_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_addr  = m_addr_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_wdata = m_wdata_q;
    assign m_aid   = m_aid_q;

endmodule

`default_nettype wire

// File: tb/tb_xadac_obi_arbiter.sv
// ============================================================================
// Module   : tb_xadac_obi_arbiter
// Brief    : Directed self-checking bench for xadac_obi_arbiter (both
//            arbitration modes, selected by XADAC_OBI_ARB_RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xadac_obi_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s0_req, s0_gnt, s0_we, s0_rvalid, s0_rready;
    logic [31:0] s0_addr;
    logic [7:0]  s0_be;
    logic [63:0] s0_wdata, s0_rdata;
    logic [2:0]  s0_aid, s0_rid;
    logic        s1_req, s1_gnt, s1_we, s1_rvalid, s1_rready;
    logic [31:0] s1_addr;
    logic [7:0]  s1_be;
    logic [63:0] s1_wdata, s1_rdata;
    logic [2:0]  s1_aid, s1_rid;
    logic        m_req, m_gnt, m_we, m_rvalid, m_rready;
    logic [31:0] m_addr;
    logic [7:0]  m_be;
    logic [63:0] m_wdata, m_rdata;
    logic [3:0]  m_aid, m_rid;

    int checks = 0;
    int errors = 0;

    xadac_obi_arbiter dut (
        .clk(clk), .rstn(rstn),
        .s0_req(s0_req), .s0_gnt(s0_gnt), .s0_addr(s0_addr), .s0_we(s0_we),
        .s0_be(s0_be), .s0_wdata(s0_wdata), .s0_aid(s0_aid),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata),
        .s0_rid(s0_rid),
        .s1_req(s1_req), .s1_gnt(s1_gnt), .s1_addr(s1_addr), .s1_we(s1_we),
        .s1_be(s1_be), .s1_wdata(s1_wdata), .s1_aid(s1_aid),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata),
        .s1_rid(s1_rid),
        .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_we(m_we),
        .m_be(m_be), .m_wdata(m_wdata), .m_aid(m_aid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rid(m_rid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s0_req = 1'b0; s1_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        s0_rready = 1'b0; s1_rready = 1'b0; m_rid = '0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        s0_addr = '0; s0_we = 1'b0; s0_be = 8'hFF; s0_wdata = '0; s0_aid = '0;
        s1_addr = '0; s1_we = 1'b1; s1_be = 8'h0F; s1_wdata = 64'h1234; s1_aid = '0;
        do_reset();

        // Reset state
        chk("rst_m_req",  m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_aid",  m_aid, 0);
        chk("rst_m_be",   m_be, 0);
        chk("rst_m_we",   m_we, 0);

        // Single read on port 0 and R routing
        s0_req = 1'b1; s0_addr = 32'h100; s0_aid = 3'd2; m_gnt = 1'b1;
        #1;
        chk("single_s0_gnt", s0_gnt, 1);
        chk("single_s1_gnt", s1_gnt, 0);
        tick();
        s0_req = 1'b0;
        chk("single_m_req",  m_req, 1);
        chk("single_m_addr", m_addr, 64'h100);
        chk("single_m_aid",  m_aid, 4'b0010);
        m_rvalid = 1'b1; m_rid = 4'b0010; m_rdata = 64'hDEAD; s0_rready = 1'b1;
        #1;
        chk("r0_s0_rvalid", s0_rvalid, 1);
        chk("r0_s0_rid",    s0_rid, 2);
        chk("r0_s0_rdata",  s0_rdata, 64'hDEAD);
        chk("r0_s1_rvalid", s1_rvalid, 0);
        chk("r0_m_rready",  m_rready, 1);
        m_rid = 4'b1101; s1_rready = 1'b0;
        #1;
        chk("r1_s1_rvalid", s1_rvalid, 1);
        chk("r1_s0_rvalid", s0_rvalid, 0);
        chk("r1_s1_rid",    s1_rid, 5);
        chk("r1_m_rready",  m_rready, 0);
        m_rvalid = 1'b0;
        tick();
        chk("drain_m_req",  m_req, 0);
        chk("hold_m_addr",  m_addr, 64'h100);

        // Continuous contention
        do_reset();
        s0_aid = 3'd1; s1_aid = 3'd6; s0_req = 1'b1; s1_req = 1'b1; m_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp1;
`ifdef XADAC_OBI_ARB_RR_EN
            exp1 = (k % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            #1;
            chk($sformatf("cont%0d_s0_gnt", k), s0_gnt, !exp1);
            chk($sformatf("cont%0d_s1_gnt", k), s1_gnt, exp1);
            tick();
            chk($sformatf("cont%0d_m_aid", k), m_aid, exp1 ? 4'hE : 4'h1);
        end

        // Slice stall under m_gnt=0
        do_reset();
        s0_req = 1'b1; s0_addr = 32'hA0; s0_aid = 3'd3; m_gnt = 1'b0;
        #1;
        chk("stall_first_gnt", s0_gnt, 1);
        tick();
        s0_addr = 32'hB0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_s0_gnt", k), s0_gnt, 0);
            chk($sformatf("stall%0d_m_addr", k), m_addr, 64'hA0);
            chk($sformatf("stall%0d_m_req", k),  m_req, 1);
            tick();
        end
        m_gnt = 1'b1;
        #1;
        chk("stall_release_gnt", s0_gnt, 1);
        tick();
        chk("stall_reload_m_req",  m_req, 1);
        chk("stall_reload_m_addr", m_addr, 64'hB0);

        // Port 1 outstanding limit
        do_reset();
        s1_req = 1'b1; m_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("lim%0d_s1_gnt", k), s1_gnt, 1);
            tick();
        end
        s0_req = 1'b1;
        #1;
        chk("lim_full_s1_gnt", s1_gnt, 0);
        chk("lim_full_s0_gnt", s0_gnt, 1);
        tick();
        s0_req = 1'b0;
        m_rvalid = 1'b1; m_rid = 4'b1000; s1_rready = 1'b1;
        #1;
        chk("lim_rsp_same_cycle_gnt", s1_gnt, 0);
        tick();
        m_rvalid = 1'b0; s1_rready = 1'b0;
        #1;
        chk("lim_after_rsp_gnt", s1_gnt, 1);
        tick();

        // Simultaneous grant and response on port 0 keeps the count
        do_reset();
        s0_req = 1'b1; m_gnt = 1'b1;
        tick();
        tick();
        m_rvalid = 1'b1; m_rid = 4'b0001; s0_rready = 1'b1;
        #1;
        chk("both_s0_gnt",    s0_gnt, 1);
        chk("both_s0_rvalid", s0_rvalid, 1);
        tick();
        m_rvalid = 1'b0; s0_rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("both_fill%0d_gnt", k), s0_gnt, 1);
            tick();
        end
        #1;
        chk("both_full_gnt", s0_gnt, 0);

        // Asynchronous reset mid-operation
        do_reset();
        s0_req = 1'b1; s0_addr = 32'h300; m_gnt = 1'b1;
        tick();
        tick();
        tick();
        s0_req = 1'b0;
        chk("arst_pre_m_req", m_req, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_m_req",  m_req, 0);
        chk("arst_m_addr", m_addr, 0);
        chk("arst_m_aid",  m_aid, 0);
        #1;
        rstn = 1'b1;
        s0_req = 1'b1; s1_req = 1'b1;
        #1;
        chk("arst_first_s0_gnt", s0_gnt, 1);
        chk("arst_first_s1_gnt", s1_gnt, 0);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
